spi_xfer_engine: RTL and testbench
==================================

Name: spi_xfer_engine

Overview:
- Byte-level SPI mode-0 master shift engine.
- Sits directly downstream of the command FSM and byte counter. It serialises a 1–3 byte command frame onto MOSI, captures MISO into a receive register, and pulses done at frame end.
- Owns sclk generation, cs_n framing and bit timing. This replaces ad-hoc divider and done logic in the top-level SPI wrapper.

Parameters:
- CLK_DIV, 10, clk cycles per sclk half-period; 100 MHz clk gives 5 MHz sclk; legal range 2..255.
- MAX_BYTES, 3, maximum bytes per frame; also sets the width of the tx_data and rx_data buses.

Ports:
- clk  input  1  system clock (100 MHz).
- rst  input  1  reset; synchronous, active-high.
- start  input  1  frame request, sampled on clk rising edge.
- data_size  input  3  bytes in frame; legal range 1..MAX_BYTES.
- tx_data  input  8*MAX_BYTES  frame bytes; byte 0 in the MSBs (tx_data[8*MAX_BYTES-1 -: 8]).
- miso  input  1  serial data from slave.
- busy  output  1  high from the start-accept cycle until the engine returns to IDLE.
- done  output  1  one-cycle pulse at frame completion.
- rx_data  output  8*MAX_BYTES  received bytes; first byte in the MSBs; unused low bytes are zero.
- sclk  output  1  serial clock; CPOL=0.
- mosi  output  1  serial data to slave, MSB first.
- cs_n  output  1  chip select, active-low.

Behaviour:
- Reset values: cs_n=1, sclk=0, mosi=0, busy=0, done=0, rx_data=0. All internal counters and state go to 0/IDLE.
- Reset mid-frame: on the next clk edge, return to IDLE with the reset values above. No done pulse. The partial rx_data is discarded.
- States: IDLE, SETUP, SHIFT, HOLD, GAP.
- Start acceptance:
  - In IDLE, start=1 with data_size in 1..MAX_BYTES is accepted.
  - On acceptance: latch tx_data and data_size, set busy=1, move to SETUP.
  - Define edge 0 as the clk edge that samples start.
  - Start with data_size=0 or data_size>MAX_BYTES is ignored (no busy, no done).
  - Start while busy=1 is ignored.
- SETUP:
  - From cycle 1: cs_n=0, mosi = latched byte 0 bit 7, sclk=0.
  - Hold for CLK_DIV cycles, then go to SHIFT.
- SHIFT:
  - Let N = 8*data_size.
  - For bit k = 0..N-1: sclk rises at cycle 1 + CLK_DIV*(2k+1) and falls at cycle 1 + CLK_DIV*(2k+2).
  - miso is sampled into the rx shift register on the clk edge where sclk goes 0→1.
  - mosi advances to the next bit on the clk edge where sclk goes 1→0, except after the last bit.
  - After the last falling edge, at cycle 1 + 2*CLK_DIV*N, go to HOLD.
- HOLD:
  - sclk=0, cs_n still 0, mosi held, for CLK_DIV cycles.
  - At cycle 1 + 2*CLK_DIV*N + CLK_DIV: cs_n=1, mosi=0, done=1 for exactly one cycle, and rx_data updated in the same cycle.
  - rx_data alignment: the shift register is left-shifted by 8*(MAX_BYTES - data_size) so the first byte lands in the MSBs.
- GAP:
  - cs_n=1 for CLK_DIV cycles, then IDLE with busy=0.
  - The earliest next accept is the cycle after busy falls; this guarantees a minimum cs_n high time of CLK_DIV cycles.
- rx_data holds its value until the next done or reset.
- Bit counter width: ceil(log2(8*MAX_BYTES+1)). Divider counter width: 8 bits; it wraps at CLK_DIV-1 and reloads to 0 on every state change.
- Outputs sclk, mosi, cs_n, busy and done are all registered; none are combinational from inputs.

Test Plan:
- Write frame: CLK_DIV=10, data_size=3, tx_data=0x0A2D02 -> cs_n low at cycle 1; 24 sclk rising edges, the first at cycle 11; mosi bit stream 0x0A,0x2D,0x02 MSB first; done at cycle 491; cs_n high at 491; busy low at 501.
- Read frame: data_size=3, tx_data=0x0B0800; miso model drives 0 for bytes 0–1 and 0xA5 for byte 2 (changes on sclk fall) -> rx_data=0x0000A5 at the done cycle.
- Short frame: data_size=2, tx_data=0x0B0E00, miso returns 0x3C in byte 1 -> 16 sclk pulses; rx_data=0x003C00 (wait: first byte 0x00, second byte 0x3C, low byte zero); done at cycle 331.
- Illegal and overlapping requests: start with data_size=0 -> busy stays 0, no done. Start pulsed mid-frame -> ignored; exactly one done.
- Reset mid-frame: assert rst at cycle 200 of a 3-byte frame -> next cycle cs_n=1, sclk=0, mosi=0, busy=0, rx_data=0; no done. A new start after release completes normally.
- Back-to-back frames: CLK_DIV=2, start held high continuously with data_size=1, tx_data=0x52xxxx -> frames separated by cs_n high ≥2 cycles; each frame has 8 sclk pulses and one done pulse.

Source files
------------

// File: rtl/spi_xfer_engine.sv
// spi_xfer_engine: byte-level SPI mode-0 master shift engine.
// Serialises a 1..MAX_BYTES byte frame onto mosi (MSB first), captures miso
// into a receive register and pulses done once per frame.
//
// Handshake: start is a request sampled on the rising clk edge. It is
// accepted only while the engine is IDLE with busy low and data_size in
// 1..MAX_BYTES; anything else is dropped. busy rises on the accept edge and
// falls one cycle after the engine has returned to IDLE. done is a single
// cycle pulse, coincident with cs_n rising and rx_data updating.
//
// Timing model: every output register is loaded from the state and
// counters of the previous cycle, so pin activity trails the FSM by one
// clk. With the accept edge as edge 0, cs_n falls at cycle 1 and the first
// sclk rise lands at cycle 1 + CLK_DIV.
module spi_xfer_engine #(
  parameter int CLK_DIV   = 10,
  parameter int MAX_BYTES = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [2:0]             data_size,
  input  logic [8*MAX_BYTES-1:0] tx_data,
  input  logic                   miso,
  output logic                   busy,
  output logic                   done,
  output logic [8*MAX_BYTES-1:0] rx_data,
  output logic                   sclk,
  output logic                   mosi,
  output logic                   cs_n
);

  localparam int         W        = 8 * MAX_BYTES;
  localparam int         BCW      = $clog2(W + 1);
  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [2:0] MAX_SZ   = 3'(MAX_BYTES);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } state_t;

  state_t         state_q;
  state_t         state_d;
  logic [7:0]     div_q;     // clk cycles within the current half-period
  logic           phase_q;   // 0: sclk-high half of a bit, 1: sclk-low half
  logic [BCW-1:0] bit_q;     // index of the bit currently on the wire
  logic [2:0]     size_q;    // latched byte count
  logic [W-1:0]   tx_sr;     // transmit shift register, next bit in MSB
  logic [W-1:0]   rx_sr;     // receive shift register, newest bit in LSB
  logic           accept;
  logic           div_last;
  logic           last_bit;

  assign accept   = (state_q == IDLE) && !busy && start &&
                    (data_size != 3'd0) && (data_size <= MAX_SZ);
  assign div_last = (div_q == DIV_LAST);
  assign last_bit = (bit_q == BCW'({size_q, 3'b000} - 6'd1));

  // Next-state logic. SHIFT ends after the high half of the final bit; the
  // low half of that bit is covered by HOLD so mosi never advances past it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SETUP;
      SETUP:   if (div_last) state_d = SHIFT;
      SHIFT:   if (div_last && !phase_q && last_bit) state_d = HOLD;
      HOLD:    if (div_last) state_d = GAP;
      GAP:     if (div_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register, divider and bit/phase counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      div_q   <= 8'd0;
      phase_q <= 1'b0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      if ((state_d != state_q) || div_last) div_q <= 8'd0;
      else                                  div_q <= div_q + 8'd1;
      if (state_q != SHIFT) begin
        phase_q <= 1'b0;
        bit_q   <= '0;
      end else if (div_last) begin
        if (phase_q) begin
          phase_q <= 1'b0;
          bit_q   <= bit_q + 1'b1;
        end else begin
          phase_q <= 1'b1;
        end
      end
    end
  end

  // Frame data: latch on accept, sample miso as sclk rises, shift tx as it falls.
  always_ff @(posedge clk) begin
    if (rst) begin
      size_q <= 3'd0;
      tx_sr  <= '0;
      rx_sr  <= '0;
    end else if (accept) begin
      size_q <= data_size;
      tx_sr  <= tx_data;
      rx_sr  <= '0;
    end else if ((state_q == SHIFT) && (div_q == 8'd0)) begin
      if (!phase_q) rx_sr <= {rx_sr[W-2:0], miso};
      else          tx_sr <= {tx_sr[W-2:0], 1'b0};
    end
  end

  // Registered pin outputs, busy and the done/rx_data update.
  always_ff @(posedge clk) begin
    if (rst) begin
      cs_n    <= 1'b1;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rx_data <= '0;
    end else begin
      busy <= accept || (busy && (state_q != IDLE));
      sclk <= (state_q == SHIFT) && !phase_q;
      cs_n <= !((state_q == SETUP) || (state_q == SHIFT) || (state_q == HOLD));
      done <= 1'b0;
      case (state_q)
        SETUP: mosi <= tx_sr[W-1];
        SHIFT: if (phase_q && (div_q == 8'd0)) mosi <= tx_sr[W-2];
        HOLD:  mosi <= mosi;
        default: mosi <= 1'b0;
      endcase
      // First GAP cycle: frame complete, left-align the received bytes.
      if ((state_q == GAP) && (div_q == 8'd0)) begin
        done    <= 1'b1;
        rx_data <= rx_sr << {MAX_SZ - size_q, 3'b000};
      end
    end
  end

endmodule

// File: tb/tb_spi_xfer_engine.sv
// tb_spi_xfer_engine: directed bench for spi_xfer_engine. Cycle numbers are
// counted from edge 0, the clk edge that samples start; outputs are read
// 1 ns after each rising edge.
module tb_spi_xfer_engine;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // DUT A: CLK_DIV = 10
  logic        start, miso, busy, done, sclk, mosi, cs_n;
  logic [2:0]  data_size;
  logic [23:0] tx_data, rx_data;

  // DUT B: CLK_DIV = 2, used for back-to-back frames
  logic        start2, miso2, busy2, done2, sclk2, mosi2, cs_n2;
  logic [2:0]  data_size2;
  logic [23:0] tx_data2, rx_data2;

  spi_xfer_engine #(.CLK_DIV(10), .MAX_BYTES(3)) dut (
    .clk(clk), .rst(rst), .start(start), .data_size(data_size),
    .tx_data(tx_data), .miso(miso), .busy(busy), .done(done),
    .rx_data(rx_data), .sclk(sclk), .mosi(mosi), .cs_n(cs_n)
  );

  spi_xfer_engine #(.CLK_DIV(2), .MAX_BYTES(3)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .data_size(data_size2),
    .tx_data(tx_data2), .miso(miso2), .busy(busy2), .done(done2),
    .rx_data(rx_data2), .sclk(sclk2), .mosi(mosi2), .cs_n(cs_n2)
  );

  int checks = 0;
  int errors = 0;

  // Observations collected by run_frame
  int          first_csn_low, first_rise, last_rise, rise_cnt;
  int          done_cnt, done_cyc, busy_low_cyc;
  logic        busy_at0, csn_at_done;
  logic [23:0] mosi_cap, rx_at_done;

  // ---------------- driver / monitor ----------------
  // Issues one start at edge 0 and watches DUT A for `window` cycles. A slave
  // model drives mpat (right-aligned, first bit = mpat[n-1]) on miso,
  // changing after each sclk fall. pulse_at > 0 re-raises start for one cycle.
  task automatic run_frame(input logic [2:0] size, input logic [23:0] tx,
                           input logic [23:0] mpat, input int window,
                           input int pulse_at);
    int   n;
    logic prev_sclk, prev_busy;
    n = 8 * int'(size);
    first_csn_low = -1; first_rise = -1; last_rise = -1; rise_cnt = 0;
    done_cnt = 0; done_cyc = -1; busy_low_cyc = -1;
    mosi_cap = 24'h0; rx_at_done = 24'h0; csn_at_done = 1'b0;
    @(negedge clk);
    data_size = size;
    tx_data   = tx;
    miso      = mpat[n-1];
    start     = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
    busy_at0  = busy;
    prev_sclk = sclk;
    prev_busy = busy;
    for (int c = 1; c <= window; c++) begin
      @(posedge clk); #1;
      start = (c == pulse_at);
      if (!cs_n && first_csn_low < 0) first_csn_low = c;
      if (sclk && !prev_sclk) begin
        rise_cnt++;
        if (first_rise < 0) first_rise = c;
        last_rise = c;
        mosi_cap  = {mosi_cap[22:0], mosi};
      end
      if (!sclk && prev_sclk && rise_cnt < n) miso = mpat[n-1-rise_cnt];
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc    = c;
          rx_at_done  = rx_data;
          csn_at_done = cs_n;
        end
      end
      if (!busy && prev_busy && busy_low_cyc < 0) busy_low_cyc = c;
      prev_sclk = sclk;
      prev_busy = busy;
    end
    start = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0; data_size = 3'd0; tx_data = 24'h0; miso = 1'b0;
    start2 = 1'b0; data_size2 = 3'd0; tx_data2 = 24'h0; miso2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({cs_n, sclk, mosi, busy, done} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_pins: got cs_n,sclk,mosi,busy,done=%b expected 10000",
               {cs_n, sclk, mosi, busy, done});
    end
    checks++;
    if (rx_data !== 24'h0) begin
      errors++;
      $display("FAIL reset_rx: got %h expected 000000", rx_data);
    end
    checks++;
    if ({cs_n2, sclk2, mosi2, busy2, done2} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_pins2: got %b expected 10000",
               {cs_n2, sclk2, mosi2, busy2, done2});
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_write_frame();
    run_frame(3'd3, 24'h0A2D02, 24'h000000, 520, 0);
    checks++;
    if (busy_at0 !== 1'b1) begin
      errors++; $display("FAIL write_busy_at0: got %b expected 1", busy_at0);
    end
    checks++;
    if (first_csn_low != 1) begin
      errors++; $display("FAIL write_csn_low: got cycle %0d expected 1", first_csn_low);
    end
    checks++;
    if (first_rise != 11) begin
      errors++; $display("FAIL write_first_rise: got cycle %0d expected 11", first_rise);
    end
    checks++;
    if (last_rise != 471) begin
      errors++; $display("FAIL write_last_rise: got cycle %0d expected 471", last_rise);
    end
    checks++;
    if (rise_cnt != 24) begin
      errors++; $display("FAIL write_rise_cnt: got %0d expected 24", rise_cnt);
    end
    checks++;
    if (mosi_cap !== 24'h0A2D02) begin
      errors++; $display("FAIL write_mosi: got %h expected 0a2d02", mosi_cap);
    end
    checks++;
    if (done_cyc != 491 || done_cnt != 1) begin
      errors++;
      $display("FAIL write_done: got cycle %0d count %0d expected cycle 491 count 1",
               done_cyc, done_cnt);
    end
    checks++;
    if (csn_at_done !== 1'b1) begin
      errors++; $display("FAIL write_csn_at_done: got %b expected 1", csn_at_done);
    end
    checks++;
    if (busy_low_cyc != 501) begin
      errors++; $display("FAIL write_busy_low: got cycle %0d expected 501", busy_low_cyc);
    end
  endtask

  task automatic test_read_frame();
    run_frame(3'd3, 24'h0B0800, 24'h0000A5, 510, 0);
    checks++;
    if (rx_at_done !== 24'h0000A5) begin
      errors++; $display("FAIL read_rx: got %h expected 0000a5", rx_at_done);
    end
    checks++;
    if (done_cyc != 491) begin
      errors++; $display("FAIL read_done: got cycle %0d expected 491", done_cyc);
    end
    checks++;
    if (rx_data !== 24'h0000A5) begin
      errors++; $display("FAIL read_rx_hold: got %h expected 0000a5", rx_data);
    end
  endtask

  task automatic test_short_frame();
    run_frame(3'd2, 24'h0B0E00, 24'h00003C, 350, 0);
    checks++;
    if (rise_cnt != 16) begin
      errors++; $display("FAIL short_rise_cnt: got %0d expected 16", rise_cnt);
    end
    checks++;
    if (mosi_cap[15:0] !== 16'h0B0E) begin
      errors++; $display("FAIL short_mosi: got %h expected 0b0e", mosi_cap[15:0]);
    end
    checks++;
    if (rx_at_done !== 24'h003C00) begin
      errors++; $display("FAIL short_rx: got %h expected 003c00", rx_at_done);
    end
    checks++;
    if (done_cyc != 331) begin
      errors++; $display("FAIL short_done: got cycle %0d expected 331", done_cyc);
    end
    checks++;
    if (busy_low_cyc != 341) begin
      errors++; $display("FAIL short_busy_low: got cycle %0d expected 341", busy_low_cyc);
    end
  endtask

  task automatic test_illegal_size();
    logic [2:0] sizes [2];
    sizes[0] = 3'd0;
    sizes[1] = 3'd4;
    for (int s = 0; s < 2; s++) begin
      int busy_seen, done_seen, csn_seen;
      busy_seen = 0; done_seen = 0; csn_seen = 0;
      @(negedge clk);
      data_size = sizes[s];
      tx_data   = 24'hFFFFFF;
      start     = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int c = 0; c < 40; c++) begin
        if (busy) busy_seen++;
        if (done) done_seen++;
        if (!cs_n) csn_seen++;
        @(posedge clk); #1;
      end
      checks++;
      if (busy_seen != 0 || done_seen != 0 || csn_seen != 0) begin
        errors++;
        $display("FAIL illegal_size_%0d: got busy %0d done %0d cs_low %0d cycles expected 0 0 0",
                 sizes[s], busy_seen, done_seen, csn_seen);
      end
    end
  endtask

  task automatic test_overlap_start();
    run_frame(3'd1, 24'hC30000, 24'h00005A, 220, 50);
    checks++;
    if (done_cnt != 1 || done_cyc != 171) begin
      errors++;
      $display("FAIL overlap_done: got count %0d cycle %0d expected count 1 cycle 171",
               done_cnt, done_cyc);
    end
    checks++;
    if (rise_cnt != 8) begin
      errors++; $display("FAIL overlap_rise_cnt: got %0d expected 8", rise_cnt);
    end
    checks++;
    if (mosi_cap[7:0] !== 8'hC3 || rx_at_done !== 24'h5A0000) begin
      errors++;
      $display("FAIL overlap_data: got mosi %h rx %h expected c3 5a0000",
               mosi_cap[7:0], rx_at_done);
    end
    checks++;
    if (busy_low_cyc != 181) begin
      errors++; $display("FAIL overlap_busy_low: got cycle %0d expected 181", busy_low_cyc);
    end
  endtask

  task automatic test_reset_mid_frame();
    int done_seen, csn_seen;
    done_seen = 0; csn_seen = 0;
    @(negedge clk);
    data_size = 3'd3;
    tx_data   = 24'hFFFFFF;
    miso      = 1'b1;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk); #1;
      if (done) done_seen++;
    end
    // At cycle 200 the frame is mid-bit with sclk and mosi high.
    checks++;
    if ({cs_n, sclk, mosi, busy} !== 4'b0111) begin
      errors++;
      $display("FAIL rstmid_before: got cs_n,sclk,mosi,busy=%b expected 0111",
               {cs_n, sclk, mosi, busy});
    end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({cs_n, sclk, mosi, busy, done} !== 5'b10000 || rx_data !== 24'h0) begin
      errors++;
      $display("FAIL rstmid_after: got pins %b rx %h expected 10000 000000",
               {cs_n, sclk, mosi, busy, done}, rx_data);
    end
    rst = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (done) done_seen++;
      if (!cs_n) csn_seen++;
    end
    checks++;
    if (done_seen != 0 || csn_seen != 0) begin
      errors++;
      $display("FAIL rstmid_quiet: got done %0d cs_low %0d expected 0 0", done_seen, csn_seen);
    end
    run_frame(3'd1, 24'h960000, 24'h000069, 200, 0);
    checks++;
    if (done_cyc != 171 || rx_at_done !== 24'h690000 || mosi_cap[7:0] !== 8'h96) begin
      errors++;
      $display("FAIL rstmid_recover: got done %0d rx %h mosi %h expected 171 690000 96",
               done_cyc, rx_at_done, mosi_cap[7:0]);
    end
  endtask

  task automatic test_back_to_back();
    int          dones, rises, rises_frame, high_run, min_high;
    logic        prev_sclk, prev_csn, seen_frame;
    logic [7:0]  byte_cap;
    dones = 0; rises = 0; rises_frame = 0; high_run = 0; min_high = 1000;
    seen_frame = 1'b0; byte_cap = 8'h0;
    @(negedge clk);
    data_size2 = 3'd1;
    tx_data2   = 24'h52A5C3;
    miso2      = 1'b0;
    start2     = 1'b1;
    @(posedge clk); #1;
    prev_sclk = sclk2;
    prev_csn  = cs_n2;
    for (int c = 1; c <= 150; c++) begin
      @(posedge clk); #1;
      if (sclk2 && !prev_sclk) begin
        rises++;
        rises_frame++;
        byte_cap = {byte_cap[6:0], mosi2};
      end
      if (cs_n2 && seen_frame) high_run++;
      if (!cs_n2 && prev_csn && seen_frame) begin
        if (high_run < min_high) min_high = high_run;
        high_run = 0;
      end
      if (done2) begin
        dones++;
        seen_frame = 1'b1;
        high_run   = 1;
        checks++;
        if (rises_frame != 8 || byte_cap !== 8'h52) begin
          errors++;
          $display("FAIL b2b_frame%0d: got rises %0d byte %h expected 8 52",
                   dones, rises_frame, byte_cap);
        end
        rises_frame = 0;
      end
      prev_sclk = sclk2;
      prev_csn  = cs_n2;
    end
    start2 = 1'b0;
    checks++;
    if (dones != 4 || rises != 32) begin
      errors++;
      $display("FAIL b2b_totals: got dones %0d rises %0d expected 4 32", dones, rises);
    end
    checks++;
    if (min_high < 2 || min_high == 1000) begin
      errors++;
      $display("FAIL b2b_csn_gap: got min cs_n high %0d cycles expected at least 2", min_high);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_write_frame();
    test_read_frame();
    test_short_frame();
    test_illegal_size();
    test_overlap_start();
    test_reset_mid_frame();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
